alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Execute stage behind the I/R-type operation decoder. Consumes the 4-bit ALU operation code plus operands.
//   Produces a registered result over a valid/ready handshake.
//   Non-shift ops complete in 1 cycle; shifts use a 1-bit-per-cycle serial shifter (area-lean default).
// PARAMETERS
//   XLEN     32             datapath width
//   SHAMT_W  $clog2(XLEN)   shift-amount width (localparam, derived; not overridable)
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operation/operands valid
//   in_ready   out  1        unit can accept (high only in IDLE)
//   operation  in   4        ALU op code (encoding below)
//   operand_a  in   XLEN     rs1 value
//   operand_b  in   XLEN     rs2 value or sign-extended immediate
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result
//   result     out  XLEN     registered result
//   illegal_op out  1        qualified by out_valid; op code unsupported
// BEHAVIOUR
//   Op codes: 0001 ADD, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
//     0000 and 1010-1111 are illegal.
//   Reset: state=IDLE, in_ready=1, out_valid=0, result=0, illegal_op=0, shift counter=0.
//   Accept on posedge with in_valid&&in_ready. Operands and op are captured; inputs are don't-care afterwards.
//   FSM IDLE -> EXEC/SHIFT -> DONE -> IDLE:
//     IDLE: on accept, non-shift/illegal -> DONE with result loaded; shift with shamt==0 -> DONE, result=operand_a;
//       shift with shamt!=0 -> SHIFT, shreg=operand_a, cnt=shamt.
//     SHIFT: each cycle shreg shifts by 1 (SLL: zero in at LSB; SRL: zero in at MSB; SRA: MSB replicated); cnt--.
//       When cnt==1, the shift completes and the FSM goes to DONE.
//     DONE: out_valid=1; result and illegal_op held stable while out_ready=0. On out_valid&&out_ready -> IDLE.
//   Latency (accept edge to out_valid high): 1 cycle non-shift; 1+shamt cycles for shifts (max XLEN).
//   No accept/retire overlap: in_ready=0 in SHIFT and DONE, so a new op is accepted at the earliest 1 cycle after retire.
//   Arithmetic:
//     shamt = operand_b[SHAMT_W-1:0]; upper bits are ignored.
//     ADD wraps modulo 2^XLEN; no overflow flag.
//     SLT is signed; SLTU is unsigned. Both return result = {XLEN-1 zeros, lt}.
//   Illegal op: result=0, illegal_op=1, latency 1; no other side effect.
//   Reset mid-operation (any state): asynchronously returns to IDLE. In-flight op is discarded; out_valid drops immediately.
//   out_valid never asserts without a preceding accept.
// CONFIGURATION
//   ALU_FAST_SHIFT_EN defined:
//     Shifts use a combinational barrel shifter, so every op has latency 1. SHIFT state and counter are removed.
//     Results are bit-identical to the serial build.
//   Undefined (default): serial shifter as above.
// STRUCTURE
//   Shared header mj32_alu_ops.vh:
//     ALU_OP_* 4-bit localparams for all ten codes (incl. ALU_OP_NONE=4'b0000).
//     The decoder and this unit both include it.
//   One sub-module, alu_serial_shifter:
//     Inputs: load, dir/arith select, shamt. Outputs: shreg, done.
//     Instantiated only when ALU_FAST_SHIFT_EN is undefined.
//   FSM state encoding is a local 2-bit localparam set in this file.
// TESTING
//   1 ADD 0x00000005+0x00000007, out_ready=1 -> result=0x0000000C, out_valid 1 cycle after accept, illegal_op=0.
//   2 SRA a=0x80000000, b=0x00000024 (shamt=4) -> result=0xF8000000 after 5 cycles; in_ready=0 throughout.
//   3 SLT a=0xFFFFFFFF, b=0x00000001 -> result 1; SLTU same operands -> result 0.
//   4 out_ready=0 for 3 cycles after XOR 0xFF00FF00^0x0F0F0F0F -> result=0xF00FF00F stable, out_valid=1, in_ready=0.
//     On out_ready=1 the result retires and in_ready rises next cycle.
//   5 op=4'b1111 -> out_valid with illegal_op=1, result=0. Then op=0000 -> same.
//   6 SLL by 31, rst_n low at cycle 10 -> out_valid=0, in_ready=1 immediately. After release, ADD completes normally.
//   Run all scenarios with and without ALU_FAST_SHIFT_EN; compare results against a reference model; latency checks are per build.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// ALU op-code constants shared by the operation decoder and the execute unit,
// plus small op-classification helpers.
package alu_exec_unit_pkg;

    localparam logic [3:0] ALU_OP_NONE = 4'b0000;
    localparam logic [3:0] ALU_OP_ADD  = 4'b0001;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0010;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0011;
    localparam logic [3:0] ALU_OP_SLTU = 4'b0100;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0101;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0110;
    localparam logic [3:0] ALU_OP_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OP_OR   = 4'b1000;
    localparam logic [3:0] ALU_OP_AND  = 4'b1001;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op >= ALU_OP_ADD) && (op <= ALU_OP_AND);
    endfunction

    function automatic logic op_is_shift(input logic [3:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// One-bit-per-cycle shifter: loads operand and amount, shifts while the count is non-zero.
// done flags the cycle whose clock edge performs the final shift.
module alu_serial_shifter #(
    parameter int XLEN = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      left,
    input  logic                      arith,
    input  logic [$clog2(XLEN)-1:0]   shamt,
    input  logic [XLEN-1:0]           din,
    output logic [XLEN-1:0]           shreg,
    output logic                      done
);
    localparam int SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] cnt;
    logic               left_q;
    logic               arith_q;

    assign done = (cnt == SHAMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            cnt     <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            shreg   <= din;
            cnt     <= shamt;
            left_q  <= left;
            arith_q <= arith;
        end else if (cnt != '0) begin
            // right shifts fill with the sign bit only for SRA
            shreg <= left_q ? {shreg[XLEN-2:0], 1'b0}
                            : {arith_q & shreg[XLEN-1], shreg[XLEN-1:1]};
            cnt   <= cnt - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage with valid/ready handshake. Shifts are serial by default;
// defining ALU_FAST_SHIFT_EN swaps in a combinational barrel shifter (all ops latency 1).
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal_op
);
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
`ifndef ALU_FAST_SHIFT_EN
        ST_SHIFT = 2'b01,
`endif
        ST_DONE  = 2'b10
    } state_t;

    state_t              state, state_d;
    logic [XLEN-1:0]     res_q, res_d, alu_res;
    logic                ill_q, ill_d;
    logic [SHAMT_W-1:0]  shamt;
    logic                accept;

    assign shamt     = operand_b[SHAMT_W-1:0];
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign illegal_op = ill_q;

    always_comb begin
        alu_res = '0;
        case (operation)
            ALU_OP_ADD:  alu_res = operand_a + operand_b;
            ALU_OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            ALU_OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            ALU_OP_XOR:  alu_res = operand_a ^ operand_b;
            ALU_OP_OR:   alu_res = operand_a | operand_b;
            ALU_OP_AND:  alu_res = operand_a & operand_b;
`ifdef ALU_FAST_SHIFT_EN
            ALU_OP_SLL:  alu_res = operand_a << shamt;
            ALU_OP_SRL:  alu_res = operand_a >> shamt;
            ALU_OP_SRA:  alu_res = $signed(operand_a) >>> shamt;
`endif
            default:     alu_res = '0;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign result = res_q;
`else
    logic            sh_load, sh_done;
    logic            sel_q, sel_d;
    logic [XLEN-1:0] shreg;

    // shift results are read straight from the shifter register, which holds once the count expires
    assign result = sel_q ? shreg : res_q;

    alu_serial_shifter #(.XLEN(XLEN)) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sh_load),
        .left  (operation == ALU_OP_SLL),
        .arith (operation == ALU_OP_SRA),
        .shamt (shamt),
        .din   (operand_a),
        .shreg (shreg),
        .done  (sh_done)
    );
`endif

    always_comb begin
        state_d = state;
        res_d   = res_q;
        ill_d   = ill_q;
`ifndef ALU_FAST_SHIFT_EN
        sh_load = 1'b0;
        sel_d   = sel_q;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    res_d   = alu_res;
                    ill_d   = !op_is_legal(operation);
                    state_d = ST_DONE;
`ifndef ALU_FAST_SHIFT_EN
                    sel_d = 1'b0;
                    if (op_is_shift(operation)) begin
                        sh_load = 1'b1;
                        sel_d   = 1'b1;
                        if (shamt != '0) state_d = ST_SHIFT;
                    end
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            ST_SHIFT: if (sh_done) state_d = ST_DONE;
`endif
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            res_q <= '0;
            ill_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            sel_q <= 1'b0;
`endif
        end else begin
            state <= state_d;
            res_q <= res_d;
            ill_q <= ill_d;
`ifndef ALU_FAST_SHIFT_EN
            sel_q <= sel_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_alu_exec_unit;
    localparam int XLEN = 32;
`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      operation = 4'd0;
    logic [XLEN-1:0] operand_a = '0;
    logic [XLEN-1:0] operand_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            illegal_op;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd1: return a + b;
            4'd2: return a << sh;
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: return 32'($signed(a) >>> sh);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        bit is_sh;
        is_sh = (op == 4'd2) || (op == 4'd6) || (op == 4'd7);
        return (FAST || !is_sh) ? 1 : 1 + int'(b[4:0]);
    endfunction

    bit              m_busy = 1'b0;
    bit              m_valid = 1'b0;
    int              m_rem = 0;
    logic [31:0]     m_res = '0;
    logic            m_ill = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int l;
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_rem = 0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin m_busy = 1'b0; m_valid = 1'b1; end
        end else if (in_valid) begin
            m_res = ref_result(operation, operand_a, operand_b);
            m_ill = !(operation >= 4'd1 && operation <= 4'd9);
            l = ref_latency(operation, operand_b);
            if (l == 1) m_valid = 1'b1;
            else begin m_busy = 1'b1; m_rem = l - 1; end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("handshake{out_valid,in_ready}", {30'd0, out_valid, in_ready},
                    {30'd0, m_valid, !m_busy && !m_valid});
                if (m_valid) begin
                    chk("model_result", result, m_res);
                    chk("model_illegal", {31'd0, illegal_op}, {31'd0, m_ill});
                end
            end
        end
    endtask

    // Issue one op, wait for its result; lat counts the accept cycle as 1.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] r, output logic ill, output int lat, output bit rdy_seen);
        int t;
        out_ready = (hold == 0);
        rdy_seen  = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; operation = op; operand_a = a; operand_b = b;
        t = 0;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; operation = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
        if (in_ready) rdy_seen = 1'b1;
        r = result; ill = illegal_op;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_stable", {out_valid, in_ready, illegal_op, result[28:0]}, {1'b1, 1'b0, ill, r[28:0]});
            chk("hold_result", result, r);
        end
        if (hold > 0) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("retire_in_ready", {30'd0, in_ready, out_valid}, 32'd2);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        logic        ill;
        int          lat;
        bit          rdy;

        fork compare_loop(); join_none

        repeat (2) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
        @(negedge clk); rst_n = 1'b1; chk_en = 1'b1;

        do_op(4'd1, 32'h5, 32'h7, 0, r, ill, lat, rdy);
        chk("add_result", r, 32'hC);
        chk("add_illegal", {31'd0, ill}, 32'd0);
        chk("add_latency", lat, 1);

        do_op(4'd7, 32'h8000_0000, 32'h24, 0, r, ill, lat, rdy);
        chk("sra_result", r, 32'hF800_0000);
        chk("sra_latency", lat, FAST ? 1 : 5);
        chk("sra_in_ready_low", {31'd0, rdy}, 32'd0);

        do_op(4'd3, 32'hFFFF_FFFF, 32'h1, 0, r, ill, lat, rdy);
        chk("slt_result", r, 32'd1);
        do_op(4'd4, 32'hFFFF_FFFF, 32'h1, 0, r, ill, lat, rdy);
        chk("sltu_result", r, 32'd0);

        do_op(4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, 3, r, ill, lat, rdy);
        chk("xor_result", r, 32'hF00F_F00F);

        do_op(4'hF, 32'h1234_5678, 32'h9, 0, r, ill, lat, rdy);
        chk("illegal_f_result", r, 32'd0);
        chk("illegal_f_flag", {31'd0, ill}, 32'd1);
        chk("illegal_f_latency", lat, 1);
        do_op(4'h0, 32'hDEAD_BEEF, 32'h3, 0, r, ill, lat, rdy);
        chk("illegal_0_result", r, 32'd0);
        chk("illegal_0_flag", {31'd0, ill}, 32'd1);

        do_op(4'd6, 32'h1234_5678, 32'hFFFF_FFE0, 0, r, ill, lat, rdy);
        chk("srl_shamt0_result", r, 32'h1234_5678);
        chk("srl_shamt0_latency", lat, 1);

        do_op(4'd2, 32'h1, 32'h1F, 0, r, ill, lat, rdy);
        chk("sll31_result", r, 32'h8000_0000);
        chk("sll31_latency", lat, FAST ? 1 : 32);

        // reset while an SLL by 31 is in flight
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; operation = 4'd2; operand_a = 32'h3; operand_b = 32'h1F;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
        do_op(4'd1, 32'h10, 32'h20, 0, r, ill, lat, rdy);
        chk("post_reset_add", r, 32'h30);
        chk("post_reset_latency", lat, 1);

        // randomized traffic, checked each cycle by the compare loop
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            operation = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: operand_a = 32'h8000_0000;
                1: operand_a = 32'hFFFF_FFFF;
                default: operand_a = $urandom;
            endcase
            operand_b = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
